// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, register map and CTRL bit positions for the DMA controller.
package dma_pkg;
   typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, DONE} dma_state_t;
   localparam logic [15:0] DMA_BASE_ADDR = 16'h80F0;
   localparam logic [15:0] DMA_NUM_REGS = 16'd6;
   localparam logic [2:0] DMA_SRC_LO = 3'd0;
   localparam logic [2:0] DMA_SRC_HI = 3'd1;
   localparam logic [2:0] DMA_DST_LO = 3'd2;
   localparam logic [2:0] DMA_DST_HI = 3'd3;
   localparam logic [2:0] DMA_LEN = 3'd4;
   localparam logic [2:0] DMA_CTRL = 3'd5;
   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY = 1;
   localparam int CTRL_DONE = 2;
   localparam int CTRL_IRQ_EN = 3;
   function automatic logic [8:0] dma_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction
endpackage

// File: rtl/dma_regfile.sv
// dma_regfile: register decode, storage, registered read-back and DONE/IRQ state.
// DMA_IRQ_EN enables the stored CTRL.IRQ_EN bit and the active-low irq_n output.
module dma_regfile
   import dma_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = DMA_BASE_ADDR
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_read_en,
   input  logic        idle,
   input  logic        busy,
   input  logic        step,
   input  logic        finish,
   output logic [15:0] src,
   output logic [15:0] dst,
   output logic [7:0]  len,
   output logic        start,
   output logic        reg_hit,
   output logic [7:0]  reg_rdata,
   output logic        irq_n
);
   logic [15:0] off;
   logic [2:0] sel;
   logic hit, we, ctrl_we, done, irq_en;
   logic [7:0] rdata;
   assign off = cpu_addr - BASE_ADDR;
   assign sel = off[2:0];
   assign hit = off < DMA_NUM_REGS;
   assign we = hit && !cpu_read_en && idle;
   assign ctrl_we = we && sel == DMA_CTRL;
   assign start = ctrl_we && cpu_wdata[CTRL_START];
   // Address counters step in WR; CPU writes only land while idle, so the two never collide.
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         src <= '0;
         dst <= '0;
         len <= '0;
      end else if (step) begin
         src <= src + 16'd1;
         dst <= dst + 16'd1;
      end else if (we) begin
         if (sel == DMA_SRC_LO) src[7:0] <= cpu_wdata;
         if (sel == DMA_SRC_HI) src[15:8] <= cpu_wdata;
         if (sel == DMA_DST_LO) dst[7:0] <= cpu_wdata;
         if (sel == DMA_DST_HI) dst[15:8] <= cpu_wdata;
         if (sel == DMA_LEN) len <= cpu_wdata;
      end
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) done <= 1'b0;
      else if (finish) done <= 1'b1;
      else if (ctrl_we && (cpu_wdata[CTRL_START] || cpu_wdata[CTRL_DONE])) done <= 1'b0;
`ifdef DMA_IRQ_EN
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) irq_en <= 1'b0;
      else if (ctrl_we) irq_en <= cpu_wdata[CTRL_IRQ_EN];
   // finish term lets the interrupt assert in the DONE cycle itself
   assign irq_n = !(irq_en && (done || finish));
`else
   assign irq_en = 1'b0;
   assign irq_n = 1'b1;
`endif
   always_comb begin
      rdata = !hit ? 8'h00 :
              sel == DMA_SRC_LO ? src[7:0] :
              sel == DMA_SRC_HI ? src[15:8] :
              sel == DMA_DST_LO ? dst[7:0] :
              sel == DMA_DST_HI ? dst[15:8] :
              sel == DMA_LEN ? len :
              sel == DMA_CTRL ? {4'b0000, irq_en, done, busy, 1'b0} : 8'h00;
   end
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         reg_hit <= 1'b0;
         reg_rdata <= 8'h00;
      end else begin
         reg_hit <= hit;
         reg_rdata <= rdata;
      end
endmodule

// File: rtl/dma_controller.sv
// dma_controller: memory-to-memory DMA engine that halts the CPU via RDY and owns the bus while copying.
// Optional build macro DMA_IRQ_EN enables the completion interrupt.
module dma_controller
   import dma_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = DMA_BASE_ADDR
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_read_en,
   output logic        cpu_rdy,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_read_en,
   input  logic [7:0]  mem_dout,
   output logic        reg_hit,
   output logic [7:0]  reg_rdata,
   output logic        dma_busy,
   output logic        irq_n
);
   dma_state_t state, state_nxt;
   logic [8:0] cnt;
   logic [7:0] data;
   logic [15:0] src, dst;
   logic [7:0] len;
   logic start, dma_rd;
   dma_regfile #(.BASE_ADDR(BASE_ADDR)) u_regs (
      .clk(clk),
      .nrst(nrst),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_read_en(cpu_read_en),
      .idle(state == IDLE),
      .busy(dma_busy),
      .step(state == WR),
      .finish(state == DONE),
      .src(src),
      .dst(dst),
      .len(len),
      .start(start),
      .reg_hit(reg_hit),
      .reg_rdata(reg_rdata),
      .irq_n(irq_n)
   );
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= IDLE;
         cnt <= '0;
         data <= '0;
      end else begin
         state <= state_nxt;
         if (start) cnt <= dma_count(len);
         else if (state == WR) cnt <= cnt - 9'd1;
         if (state == CAP) data <= mem_dout;
      end
   // REQ waits for a CPU read cycle: a write cycle in flight cannot be halted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = start ? REQ : IDLE;
         REQ:  state_nxt = cpu_read_en ? RD : REQ;
         RD:   state_nxt = CAP;
         CAP:  state_nxt = WR;
         WR:   state_nxt = (cnt == 9'd1) ? DONE : RD;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   assign dma_rd = state == RD || state == CAP;
   assign dma_busy = state != IDLE;
   assign cpu_rdy = state == IDLE || state == DONE;
   assign mem_addr = dma_rd ? src : state == WR ? dst : cpu_addr;
   assign mem_din = state == WR ? data : cpu_wdata;
   assign mem_read_en = dma_rd ? 1'b1 : state == WR ? 1'b0 : cpu_read_en;
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: self-checking bench with a bus memory, a byte-level copy reference model and register tables.
// Expectations adapt to DMA_IRQ_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dma_controller;
   localparam logic [15:0] BASE = 16'h80F0;
`ifdef DMA_IRQ_EN
   localparam logic IRQ = 1'b1;
`else
   localparam logic IRQ = 1'b0;
`endif
   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [15:0] cpu_addr = 16'h0123;
   logic [7:0] cpu_wdata = 8'h00;
   logic cpu_read_en = 1'b1;
   logic cpu_rdy, mem_read_en, reg_hit, dma_busy, irq_n;
   logic [15:0] mem_addr;
   logic [7:0] mem_din, mem_dout, reg_rdata;
   logic [7:0] ram [512];
   logic [7:0] rom [512];
   logic [7:0] ref_ram [512];
   logic irq_en_exp = 1'b0;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic [15:0] addr;
      logic [7:0] wdata;
      logic hit;
      logic [7:0] rdata;
   } vec_t;
   vec_t tbl [9];

   always #5 clk = ~clk;

   dma_controller dut (
      .clk(clk),
      .nrst(nrst),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_read_en(cpu_read_en),
      .cpu_rdy(cpu_rdy),
      .mem_addr(mem_addr),
      .mem_din(mem_din),
      .mem_read_en(mem_read_en),
      .mem_dout(mem_dout),
      .reg_hit(reg_hit),
      .reg_rdata(reg_rdata),
      .dma_busy(dma_busy),
      .irq_n(irq_n)
   );

   // Bus decoder: RAM 0x0000-0x01FF, ROM 0xFE00-0xFFFF, registered read data
   always @(posedge clk) begin
      mem_dout <= mem_addr < 16'h0200 ? ram[mem_addr[8:0]] :
                  mem_addr >= 16'hFE00 ? rom[mem_addr[8:0]] : 8'h00;
      if (!mem_read_en && mem_addr < 16'h0200) ram[mem_addr[8:0]] <= mem_din;
   end

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return a < 16'h0200 ? ref_ram[a[8:0]] : a >= 16'hFE00 ? rom[a[8:0]] : 8'h00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_wdata = d;
      cpu_read_en = 1'b0;
      @(negedge clk);
      cpu_addr = 16'h0000;
      cpu_read_en = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
      cpu_addr = a;
      cpu_read_en = 1'b1;
      @(negedge clk);
      chk({name, " hit"}, {31'd0, reg_hit}, 32'd1);
      chk(name, {24'd0, reg_rdata}, {24'd0, exp});
   endtask

   task automatic ram_chk(input string name);
      int diff = 0;
      for (int a = 0; a < 512; a++) if (ram[a] !== ref_ram[a]) diff++;
      chk({name, " ram"}, diff, 0);
   endtask

   task automatic xfer(input string name, input logic [15:0] s, input logic [15:0] d,
                       input logic [7:0] l, input int hold, input logic ie);
      int n, i, p, badc, fk;
      logic [15:0] ea, wa, fa, fea;
      logic [7:0] e, fd, fed;
      logic fr;
      n = (l == 8'd0) ? 256 : int'(l);
      wr(BASE, s[7:0]);
      wr(BASE + 16'd1, s[15:8]);
      wr(BASE + 16'd2, d[7:0]);
      wr(BASE + 16'd3, d[15:8]);
      wr(BASE + 16'd4, l);
      cpu_addr = BASE + 16'd5;
      cpu_wdata = {4'b0000, ie, 3'b001};
      cpu_read_en = 1'b0;
      irq_en_exp = ie & IRQ;
      @(negedge clk);
      chk({name, " rdy_fall"}, {31'd0, cpu_rdy}, 32'd0);
      // CPU write cycles in REQ pass through and must not touch the registers
      for (int j = 0; j < hold; j++) begin
         cpu_addr = BASE + 16'(j);
         cpu_wdata = 8'hA5;
         cpu_read_en = 1'b0;
         #1;
         chk({name, " req_pass"}, {14'd0, cpu_rdy, mem_read_en, mem_addr}, {16'd0, BASE + 16'(j)});
         @(negedge clk);
      end
      cpu_addr = 16'h0000;
      cpu_read_en = 1'b1;
      badc = 0;
      fk = 0; fa = 0; fea = 0; fd = 0; fed = 0; fr = 0;
      for (int k = 0; k < 3 * n; k++) begin
         @(negedge clk);
         i = k / 3;
         p = k % 3;
         wa = d + 16'(i);
         ea = (p == 2) ? wa : s + 16'(i);
         e = ref_rd(s + 16'(i));
         if (cpu_rdy !== 1'b0 || dma_busy !== 1'b1 || mem_addr !== ea ||
             mem_read_en !== (p != 2) || (p == 2 && mem_din !== e)) begin
            if (badc == 0) begin
               fk = k; fa = mem_addr; fr = mem_read_en; fd = mem_din; fea = ea; fed = e;
            end
            badc++;
         end
         if (p == 2 && wa < 16'h0200) ref_ram[wa[8:0]] = e;
      end
      total++;
      if (badc != 0) begin
         bad++;
         $display("FAIL %s bus: %0d bad cycles, first cycle %0d got addr=%h re=%b din=%h want addr=%h re=%b din=%h",
                  name, badc, fk, fa, fr, fd, fea, fk % 3 != 2, fed);
      end
      @(negedge clk);
      chk({name, " done_cyc"}, {12'd0, cpu_rdy, dma_busy, irq_n, mem_read_en, mem_addr},
          {12'd0, 1'b1, 1'b1, ~irq_en_exp, 1'b1, 16'h0000});
      @(negedge clk);
      chk({name, " idle"}, {30'd0, dma_busy, irq_n}, {30'd0, 1'b0, ~irq_en_exp});
      rd_chk({name, " src_lo"}, BASE, 8'((s + 16'(n)) & 16'h00FF));
      rd_chk({name, " src_hi"}, BASE + 16'd1, 8'((s + 16'(n)) >> 8));
      rd_chk({name, " dst_lo"}, BASE + 16'd2, 8'((d + 16'(n)) & 16'h00FF));
      rd_chk({name, " dst_hi"}, BASE + 16'd3, 8'((d + 16'(n)) >> 8));
      rd_chk({name, " len"}, BASE + 16'd4, l);
      rd_chk({name, " ctrl"}, BASE + 16'd5, {4'b0000, irq_en_exp, 3'b100});
      ram_chk(name);
   endtask

   initial begin
      logic [15:0] s, d;
      logic [7:0] l;
      for (int a = 0; a < 512; a++) begin
         ram[a] = 8'($urandom);
         ref_ram[a] = ram[a];
         rom[a] = 8'($urandom);
      end
      #1;
      chk("rst_out", {27'd0, cpu_rdy, dma_busy, irq_n, reg_hit, mem_read_en}, {27'd0, 5'b10101});
      chk("rst_rdata", {24'd0, reg_rdata}, 32'd0);
      chk("rst_pass", {16'd0, mem_addr}, 32'h0123);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      cpu_addr = 16'h0000;
      @(negedge clk);
      for (int r = 0; r < 6; r++) rd_chk("rst_reg", BASE + 16'(r), 8'h00);

      tbl[0] = '{BASE, 8'h34, 1'b1, 8'h34};
      tbl[1] = '{BASE + 16'd1, 8'h12, 1'b1, 8'h12};
      tbl[2] = '{BASE + 16'd2, 8'hCD, 1'b1, 8'hCD};
      tbl[3] = '{BASE + 16'd3, 8'hAB, 1'b1, 8'hAB};
      tbl[4] = '{BASE + 16'd4, 8'h07, 1'b1, 8'h07};
      tbl[5] = '{BASE + 16'd5, 8'h0A, 1'b1, IRQ ? 8'h08 : 8'h00};
      tbl[6] = '{BASE + 16'd5, 8'h04, 1'b1, 8'h00};
      tbl[7] = '{BASE + 16'd6, 8'h55, 1'b0, 8'h00};
      tbl[8] = '{BASE - 16'd1, 8'h55, 1'b0, 8'h00};
      for (int t = 0; t < 9; t++) begin
         wr(tbl[t].addr, tbl[t].wdata);
         cpu_addr = tbl[t].addr;
         @(negedge clk);
         chk($sformatf("tbl%0d hit", t), {31'd0, reg_hit}, {31'd0, tbl[t].hit});
         if (tbl[t].hit) chk($sformatf("tbl%0d rdata", t), {24'd0, reg_rdata}, {24'd0, tbl[t].rdata});
      end

      xfer("copy4", 16'h0000, 16'h0100, 8'd4, 0, 1'b0);
      xfer("rom", 16'hFE00, 16'h0010, 8'd1, 0, 1'b0);
      xfer("len0", 16'h0000, 16'h0100, 8'd0, 0, 1'b0);
      xfer("hold", 16'h0050, 16'h0150, 8'd3, 3, 1'b0);
      xfer("wrap", 16'hFFFF, 16'h0020, 8'd2, 1, 1'b0);
      xfer("irq", 16'h0030, 16'h0040, 8'd1, 0, 1'b1);
      wr(BASE + 16'd5, 8'h04);
      chk("irq_release", {31'd0, irq_n}, 32'd1);
      rd_chk("irq_ctrl", BASE + 16'd5, 8'h00);
      xfer("overlap", 16'h0060, 16'h0062, 8'd6, 0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         l = 8'($urandom_range(1, 24));
         s = $urandom_range(0, 1) ? 16'($urandom_range(0, 511 - int'(l))) :
                                    16'hFE00 + 16'($urandom_range(0, 511 - int'(l)));
         d = 16'($urandom_range(0, 511 - int'(l)));
         xfer($sformatf("rand%0d", r), s, d, l, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of a copy, with a register read in flight
      wr(BASE, 8'h00);
      wr(BASE + 16'd1, 8'h00);
      wr(BASE + 16'd2, 8'h00);
      wr(BASE + 16'd3, 8'h01);
      wr(BASE + 16'd4, 8'h04);
      wr(BASE + 16'd5, 8'h09);
      cpu_addr = BASE + 16'd4;
      repeat (6) @(negedge clk);
      chk("mid_busy", {29'd0, cpu_rdy, dma_busy, reg_hit}, {29'd0, 3'b011});
      cpu_addr = 16'h1234;
      nrst = 1'b0;
      #1;
      chk("mid_rst_out", {27'd0, cpu_rdy, dma_busy, irq_n, reg_hit, mem_read_en}, {27'd0, 5'b10101});
      chk("mid_rst_rd", {8'd0, reg_rdata, mem_addr}, 32'h0000_1234);
      @(negedge clk);
      nrst = 1'b1;
      cpu_addr = 16'h0000;
      irq_en_exp = 1'b0;
      @(negedge clk);
      for (int r = 0; r < 6; r++) rd_chk("mid_rst_reg", BASE + 16'(r), 8'h00);
      for (int a = 0; a < 512; a++) ref_ram[a] = ram[a];
      xfer("after_rst", 16'h0008, 16'h0180, 8'd5, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dma_controller.md
# dma_controller

Memory-to-memory DMA engine and bus arbiter for the demo system. It sits between the CPU core and the memory-mapped bus decoder (RAM 0x0000–0x01FF, ROM 0xFE00–0xFFFF, IO page 0x80xx). It holds a small register file in the IO page. When started, it halts the CPU through its RDY input, takes the bus, copies a block of up to 256 bytes, then returns the bus to the CPU.

## Interface
Parameters:
- `BASE_ADDR`, 16'h80F0: address of register 0; six consecutive registers.

Ports:
- `clk` in 1: system clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_read_en` in 1: 1 = CPU read cycle, 0 = write cycle.
- `cpu_rdy` out 1: CPU ready; 0 halts the CPU.
- `mem_addr` out 16: bus address to the decoder.
- `mem_din` out 8: bus write data.
- `mem_read_en` out 1: bus read enable (0 = write).
- `mem_dout` in 8: decoder read data, registered (valid the cycle after the address).
- `reg_hit` out 1: registered; 1 when the previous cycle's CPU address hit the DMA registers. The top level muxes `reg_rdata` in place of `mem_dout` when this is 1.
- `reg_rdata` out 8: registered register read data.
- `dma_busy` out 1: 1 in any state other than IDLE.
- `irq_n` out 1: completion interrupt, active-low.

## Operation
Registers, at offsets from `BASE_ADDR`:
- 0 SRC_LO
- 1 SRC_HI
- 2 DST_LO
- 3 DST_HI
- 4 LEN: 0 means 256 bytes.
- 5 CTRL: bit0 START (write-1, reads 0), bit1 BUSY (read-only), bit2 DONE (write-1-to-clear), bit3 IRQ_EN.

Register writes:
- A register write happens when `cpu_read_en`=0, the address hits, and state is IDLE.
- Writes in any other state are ignored.
- Writing CTRL with START=1 clears DONE and enters REQ.

State machine:
- IDLE: the bus is muxed to the CPU and `cpu_rdy`=1.
- REQ: `cpu_rdy`=0 and the bus stays with the CPU. Go to RD on the first cycle with `cpu_read_en`=1, because write cycles cannot be halted.
- RD: `mem_addr`=src, `mem_read_en`=1.
- CAP: `mem_addr`=src held, so the decoder's chip select selects the source region. Latch `mem_dout` into the data register.
- WR: `mem_addr`=dst, `mem_din`=data register, `mem_read_en`=0. On exit:
  - src+1 and dst+1, each a 16-bit wrap (0xFFFF→0x0000).
  - Count−1, using a 9-bit internal count loaded as LEN==0 ? 256 : LEN.
  - If count reaches 0, go to DONE; otherwise go to RD.
- DONE: one cycle. Bus returns to the CPU, `cpu_rdy`=1, CTRL.DONE set, go to IDLE.

Register contents after a transfer:
- SRC and DST read back their final incremented values.
- LEN is unchanged.

During RD, CAP and WR, `cpu_rdy`=0 and all mem_* outputs come from the DMA.

## Timing
- Reset values:
  - `cpu_rdy`=1, `dma_busy`=0, `irq_n`=1, `reg_hit`=0, `reg_rdata`=0.
  - All registers 0, state IDLE.
  - mem_* pass the CPU signals through.
- Reset mid-transfer aborts immediately. Memory is left partially written and the CPU resumes from reset.
- A START write at cycle T gives REQ at T+1, so `cpu_rdy` falls at T+1.
- A transfer of N bytes takes 3N cycles from RD entry to DONE entry. `cpu_rdy` returns to 1 in the DONE cycle.
- Register reads return one cycle after the address, on `reg_rdata`/`reg_hit`.
- Source and destination may overlap. The copy is strictly ascending, one byte at a time, with no buffering.
- Writes to ROM addresses are issued on the bus and have no effect.

## Configuration
- `DMA_IRQ_EN` defined:
  - `irq_n`=0 while DONE=1 and IRQ_EN=1.
  - Cleared by writing 1 to CTRL bit2.
- `DMA_IRQ_EN` undefined:
  - `irq_n` tied to 1.
  - CTRL bit3 is not stored and reads 0.
  - DONE still works for polling.

## Structure
- Shared package `dma_pkg`:
  - State enum `dma_state_t` (IDLE, REQ, RD, CAP, WR, DONE).
  - Register offset constants `DMA_SRC_LO`…`DMA_CTRL`.
  - CTRL bit index constants.
  - Default `BASE_ADDR`.
- Sub-module `dma_regfile`: address decode, register storage, read-data register and the DONE/IRQ logic.
- Top module: FSM, counters and bus mux.

## Test plan
- Reset mid-copy: write SRC=0x0000, DST=0x0100, LEN=4, then CTRL=0x01. Expected:
  - `cpu_rdy`=0 the next cycle.
  - 12 cycles of RD/CAP/WR after the first read cycle.
  - RAM[0x100..0x103] equals RAM[0x000..0x003].
  - CTRL reads 0x04.
  - Asserting `nrst` mid-copy returns all outputs to reset values at once.
- ROM source: SRC=0xFE00, DST=0x0010, LEN=1. Expected:
  - During CAP, `mem_addr` is 0xFE00 and ROM data is latched.
  - RAM[0x010]=ROM[0x000].
- LEN=0: SRC=0x0000, DST=0x0100. Expected:
  - 256 bytes copied in 768 transfer cycles.
  - SRC reads 0x0100 and DST reads 0x0200 afterwards.
- Start during a write: hold `cpu_read_en`=0 for 3 cycles after the START write. Expected: state stays REQ and `mem_addr` follows `cpu_addr` until `cpu_read_en`=1.
- Address wrap: SRC=0xFFFF, LEN=2. Expected: the second read is at 0x0000.
- With `DMA_IRQ_EN`: set IRQ_EN and copy 1 byte. Expected:
  - `irq_n`=0 from the DONE cycle onward.
  - Writing CTRL=0x04 releases `irq_n`.
  - Without the macro, `irq_n` stays 1 throughout.
